dot_sched: RTL

Round-robin scheduler that time-shares one pipelined `fixed_dot` unit (3-cycle latency, one issue per cycle) between `N_REQ` requesters in the render pipeline. Typical clients are vertex-transform, normal-shading and culling stages. It accepts one operand pair per cycle through valid/ready handshakes and drives the pair into the dot unit. It tracks the issuing requester's ID alongside the data pipeline and returns each result on a shared, ID-tagged result bus exactly 3 cycles after acceptance.

---
 rtl/dot_sched_pkg.sv | 35 +++
 rtl/fixed_dot.sv | 38 +++
 rtl/dot_sched.sv | 91 +++++++++
 3 files changed

// File: rtl/dot_sched_pkg.sv
// Shared types, latency constant and round-robin pick helper for the dot-product scheduler.
package dot_sched_pkg;

  localparam int TOTAL_PREC_DEF = 27;
  localparam int FRAC_BITS_DEF  = 22;
  localparam int DOT_LAT        = 3;
  localparam int MAX_REQ        = 8;

  typedef logic signed [TOTAL_PREC_DEF-1:0] vec3_t [2:0];

  typedef struct packed {
    logic       found;
    logic [2:0] idx;
  } rr_pick_t;

  // First set bit of valid at or after ptr, wrapping modulo n (n <= MAX_REQ).
  function automatic rr_pick_t rr_pick(input logic [MAX_REQ-1:0] valid,
                                       input logic [2:0]         ptr,
                                       input int                 n = MAX_REQ);
    rr_pick_t r;
    int       idx;
    r = '0;
    for (int k = MAX_REQ - 1; k >= 0; k--) begin
      if (k < n) begin
        idx = (int'(ptr) + k) % n;
        if (valid[3'(idx)]) begin
          r.found = 1'b1;
          r.idx   = 3'(idx);
        end
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/fixed_dot.sv
// Pipelined signed fixed-point 3-vector dot product: input regs, product regs, truncated-sum reg.
module fixed_dot #(
  parameter int TOTAL_PREC = 27,
  parameter int FRAC_BITS  = 22
) (
  input  logic                         clk,
  input  logic signed [TOTAL_PREC-1:0] a [3],
  input  logic signed [TOTAL_PREC-1:0] b [3],
  output logic signed [TOTAL_PREC-1:0] y
);

  localparam int PW = 2 * TOTAL_PREC;
  localparam int SW = PW + 2;

  logic signed [TOTAL_PREC-1:0] a_q [3];
  logic signed [TOTAL_PREC-1:0] b_q [3];
  logic signed [PW-1:0]         prod_q [3];
  logic signed [SW-1:0]         sum;

  // Data path carries no reset; contents are meaningless until a tagged result emerges.
  always_ff @(posedge clk) begin
    for (int i = 0; i < 3; i++) begin
      a_q[i]    <= a[i];
      b_q[i]    <= b[i];
      prod_q[i] <= PW'(a_q[i]) * PW'(b_q[i]);
    end
  end

  always_comb begin
    sum = SW'(prod_q[0]) + SW'(prod_q[1]) + SW'(prod_q[2]);
  end

  // Arithmetic shift floors toward -inf, then wrap to the operand width.
  always_ff @(posedge clk) begin
    y <= TOTAL_PREC'(sum >>> FRAC_BITS);
  end

endmodule

// File: rtl/dot_sched.sv
// Round-robin arbiter sharing one fixed_dot unit between N_REQ requesters, with an ID tag pipeline.
module dot_sched
  import dot_sched_pkg::*;
#(
  parameter  int N_REQ      = 4,
  parameter  int TOTAL_PREC = TOTAL_PREC_DEF,
  parameter  int FRAC_BITS  = FRAC_BITS_DEF,
  localparam int ID_W       = $clog2(N_REQ)
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [N_REQ-1:0]             req_valid,
  output logic [N_REQ-1:0]             req_ready,
  input  logic signed [TOTAL_PREC-1:0] req_a [N_REQ][3],
  input  logic signed [TOTAL_PREC-1:0] req_b [N_REQ][3],
  output logic                         res_valid,
  output logic [ID_W-1:0]              res_id,
  output logic signed [TOTAL_PREC-1:0] res_data,
  output logic [1:0]                   in_flight
);

  localparam int TAG_STAGES = 3;

  if (TAG_STAGES != DOT_LAT) begin : g_lat_check
    $error("dot_sched: tag pipeline length does not match fixed_dot latency");
  end
  if (N_REQ < 2 || N_REQ > MAX_REQ) begin : g_nreq_check
    $error("dot_sched: N_REQ must be within 2..8");
  end

  logic [ID_W-1:0]              ptr;
  rr_pick_t                     pick;
  logic                         grant;
  logic [ID_W-1:0]              gid;
  logic signed [TOTAL_PREC-1:0] dot_a [3];
  logic signed [TOTAL_PREC-1:0] dot_b [3];
  logic                         tag_v  [TAG_STAGES];
  logic [ID_W-1:0]              tag_id [TAG_STAGES];

  // Handshake: a transfer occurs when req_valid[i] && req_ready[i] at a rising clk edge.
  // req_ready is a combinational function of req_valid and ptr; requesters must not
  // make req_valid depend on req_ready. At most one ready bit is set, none while rst.
  always_comb begin
    pick      = rr_pick(MAX_REQ'(req_valid), 3'(ptr), N_REQ);
    grant     = pick.found && !rst;
    gid       = ID_W'(pick.idx);
    req_ready = '0;
    if (grant) req_ready[gid] = 1'b1;
    for (int j = 0; j < 3; j++) begin
      dot_a[j] = grant ? req_a[gid][j] : '0;
      dot_b[j] = grant ? req_b[gid][j] : '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ptr <= '0;
      for (int i = 0; i < TAG_STAGES; i++) begin
        tag_v[i]  <= 1'b0;
        tag_id[i] <= '0;
      end
    end else begin
      if (grant) ptr <= (int'(gid) == N_REQ - 1) ? '0 : gid + 1'b1;
      tag_v[0]  <= grant;
      tag_id[0] <= gid;
      for (int i = 1; i < TAG_STAGES; i++) begin
        tag_v[i]  <= tag_v[i-1];
        tag_id[i] <= tag_id[i-1];
      end
    end
  end

  always_comb begin
    in_flight = '0;
    for (int i = 0; i < TAG_STAGES; i++) in_flight = in_flight + 2'(tag_v[i]);
  end

  assign res_valid = tag_v[TAG_STAGES-1];
  assign res_id    = tag_id[TAG_STAGES-1];

  fixed_dot #(
    .TOTAL_PREC (TOTAL_PREC),
    .FRAC_BITS  (FRAC_BITS)
  ) u_dot (
    .clk (clk),
    .a   (dot_a),
    .b   (dot_b),
    .y   (res_data)
  );

endmodule
